// File: rtl/servisia_uart_pkg.sv
// Shared types and constants for the servisia UART receive path.
package servisia_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_e;

endpackage

// File: rtl/servisia_rx_fifo.sv
// Small synchronous FIFO with a registered head word. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module servisia_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_next;
    logic [AW:0]      wr_next;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (rd_ptr == wr_ptr);
    assign full    = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_next = rd_ptr + {{AW{1'b0}}, pop_ok};
    assign wr_next = wr_ptr + {{AW{1'b0}}, push_ok};

    // Storage array: written only for accepted pushes, never reset.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Read and write pointers, cleared on reset and wrapping naturally.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_next;
        end
    end

    // Head register tracks the entry that will sit at the read pointer next
    // cycle; a word pushed into the slot about to become the head is forwarded
    // from the input because the array write lands on the same edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head <= '0;
        end else if (rd_next != wr_next) begin
            if (push_ok && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
                head <= push_data;
            end else begin
                head <= mem[rd_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/servisia_uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a small
// output FIFO with a valid/ready handshake.
module servisia_uart_rx
    import servisia_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      rx_i,
    output logic [UART_DATA_BITS-1:0] data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      frame_err_o,
    output logic                      overflow_o,
    output logic                      busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_INDEX  = IW'(UART_DATA_BITS - 1);

    uart_rx_state_e            state;
    uart_rx_state_e            state_next;
    logic                      rx_meta;
    logic                      rx_q;
    logic [CW-1:0]             bit_cnt;
    logic [IW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      sample;
    logic                      shift_en;
    logic                      push;
    logic                      pop;
    logic                      frame_err_set;
    logic                      fifo_full;
    logic                      fifo_empty;

    assign sample  = (bit_cnt == '0);
    assign valid_o = !fifo_empty;
    assign pop     = valid_o && ready_i;

    // Two-stage synchroniser on the asynchronous line; idles at the mark level.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_meta <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_q    <= rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a start edge is confirmed at mid-bit, data bits are
    // taken at each bit centre, and a low stop bit parks us until the line idles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!rx_q)  state_next = START;
            START:   if (sample) state_next = rx_q ? IDLE : DATA;
            DATA:    if (sample && (bit_idx == LAST_INDEX)) state_next = STOP;
            STOP:    if (sample) state_next = rx_q ? IDLE : BREAK;
            BREAK:   if (rx_q)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: strobes for shifting, pushing and framing errors.
    always_comb begin
        busy_o        = (state != IDLE);
        shift_en      = (state == DATA) && sample;
        push          = (state == STOP) && sample && rx_q;
        frame_err_set = (state == STOP) && sample && !rx_q;
    end

    // Bit-period counter: half a bit from the start edge, then full bits.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bit_cnt <= '0;
        end else if (state == IDLE) begin
            bit_cnt <= HALF_RELOAD;
        end else if (sample) begin
            bit_cnt <= FULL_RELOAD;
        end else begin
            bit_cnt <= bit_cnt - 1'b1;
        end
    end

    // Data bit index, cleared while confirming the start bit.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bit_idx <= '0;
        end else if (state == START) begin
            bit_idx <= '0;
        end else if (shift_en) begin
            bit_idx <= bit_idx + 1'b1;
        end
    end

    // Shift register filled LSB first, so each new bit enters at the top.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shift_q <= '0;
        end else if (shift_en) begin
            shift_q <= {rx_q, shift_q[UART_DATA_BITS-1:1]};
        end
    end

    // Single-cycle error pulses, aligned with the cycle the byte would appear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            frame_err_o <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            frame_err_o <= frame_err_set;
            overflow_o  <= push && fifo_full && !pop;
        end
    end

    servisia_rx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clk_i),
        .reset_n   (rst_ni),
        .push      (push),
        .push_data (shift_q),
        .pop       (pop),
        .head      (data_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_servisia_uart_rx.sv
// Directed and randomised bench for servisia_uart_rx with a queue-based model.
module tb_servisia_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       rx_i;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overflow_o;
    logic       busy_o;

    int tests_run  = 0;
    int fail_count = 0;
    int cyc        = 0;

    logic [7:0] popped[$];
    int         rise_cyc[$];
    int         busy_fall_cyc[$];
    int         ferr_cyc[$];
    int         ovf_cyc[$];
    int         valid_cycles = 0;
    logic       prev_valid   = 1'b0;
    logic       prev_busy    = 1'b0;

    servisia_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o),
        .busy_o      (busy_o)
    );

    // Free-running clock and an edge counter used as a timestamp.
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Observer on the falling edge: records handshakes, pulses and edges.
    always @(negedge clk_i) begin
        if (valid_o && !prev_valid) rise_cyc.push_back(cyc);
        if (!busy_o && prev_busy) busy_fall_cyc.push_back(cyc);
        if (valid_o) valid_cycles = valid_cycles + 1;
        if (valid_o && ready_i) popped.push_back(data_o);
        if (frame_err_o) ferr_cyc.push_back(cyc);
        if (overflow_o) ovf_cyc.push_back(cyc);
        prev_valid = valid_o;
        prev_busy  = busy_o;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    function automatic logic [31:0] int_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] byte_at(input logic [7:0] q[$], input int i);
        if (i < q.size()) return {24'd0, q[i]};
        return 32'hFFFF_FFFF;
    endfunction

    // Hold the line at a level for n clock cycles; entered and left #1 after an edge.
    task automatic drive_line(input logic level, input int n);
        repeat (n) begin
            rx_i = level;
            @(posedge clk_i);
            #1;
        end
    endtask

    // One 8N1 frame, LSB first, with a selectable stop-bit level.
    task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit);
        drive_line(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_line(b[i], CPB);
        drive_line(stop_bit, CPB);
    endtask

    initial begin
        int         start;
        int         base_rise, base_busy, base_ferr, base_ovf, base_pop, base_valid;
        logic [7:0] model_q[$];
        logic [7:0] b;
        int         exp_ovf;
        int         gap;

        rst_ni  = 1'b0;
        rx_i    = 1'b1;
        ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_output("reset data_o", data_o, 0);
        check_output("reset valid_o", valid_o, 0);
        check_output("reset busy_o", busy_o, 0);
        check_output("reset frame_err_o", frame_err_o, 0);
        check_output("reset overflow_o", overflow_o, 0);
        rst_ni = 1'b1;
        drive_line(1'b1, 10);

        // Single byte with exact latency.
        base_rise = rise_cyc.size(); base_busy = busy_fall_cyc.size();
        base_pop = popped.size(); base_valid = valid_cycles;
        start = cyc;
        apply_stimulus(8'h48, 1'b1);
        drive_line(1'b1, 20);
        check_output("t1 valid rises", rise_cyc.size() - base_rise, 1);
        check_output("t1 valid cycle", int_at(rise_cyc, base_rise), start + 155);
        check_output("t1 valid width", valid_cycles - base_valid, 1);
        check_output("t1 busy fall cycle", int_at(busy_fall_cyc, base_busy), start + 155);
        check_output("t1 byte", byte_at(popped, base_pop), 8'h48);

        // Back-to-back "Hi".
        base_pop = popped.size(); base_ferr = ferr_cyc.size();
        apply_stimulus(8'h48, 1'b1);
        apply_stimulus(8'h69, 1'b1);
        drive_line(1'b1, 20);
        check_output("t2 pop count", popped.size() - base_pop, 2);
        check_output("t2 byte0", byte_at(popped, base_pop), 8'h48);
        check_output("t2 byte1", byte_at(popped, base_pop + 1), 8'h69);
        check_output("t2 no frame_err", ferr_cyc.size() - base_ferr, 0);

        // Glitch shorter than half a bit.
        base_rise = rise_cyc.size(); base_busy = busy_fall_cyc.size(); base_ferr = ferr_cyc.size();
        start = cyc;
        drive_line(1'b0, 4);
        drive_line(1'b1, 40);
        check_output("t3 no valid", rise_cyc.size() - base_rise, 0);
        check_output("t3 no frame_err", ferr_cyc.size() - base_ferr, 0);
        check_output("t3 busy fall cycle", int_at(busy_fall_cyc, base_busy), start + 11);

        // Framing error with a held-low line, then recovery.
        base_rise = rise_cyc.size(); base_ferr = ferr_cyc.size();
        start = cyc;
        apply_stimulus(8'h55, 1'b0);
        drive_line(1'b0, 40);
        drive_line(1'b1, 20);
        check_output("t4 frame_err count", ferr_cyc.size() - base_ferr, 1);
        check_output("t4 frame_err cycle", int_at(ferr_cyc, base_ferr), start + 155);
        check_output("t4 no valid", rise_cyc.size() - base_rise, 0);
        base_pop = popped.size();
        apply_stimulus(8'hA3, 1'b1);
        drive_line(1'b1, 20);
        check_output("t4 recovery byte", byte_at(popped, base_pop), 8'hA3);
        check_output("t4 single frame_err", ferr_cyc.size() - base_ferr, 1);

        // Overflow: consumer stalled while five bytes arrive.
        ready_i = 1'b0;
        model_q.delete();
        exp_ovf  = 0;
        base_ovf = ovf_cyc.size();
        base_pop = popped.size();
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            apply_stimulus(b, 1'b1);
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else exp_ovf++;
            check_output($sformatf("t5 overflow after byte %0d", i), ovf_cyc.size() - base_ovf, exp_ovf);
        end
        drive_line(1'b1, 10);
        check_output("t5 valid while full", valid_o, 1);
        ready_i = 1'b1;
        drive_line(1'b1, 10);
        check_output("t5 drain count", popped.size() - base_pop, model_q.size());
        for (int i = 0; i < model_q.size(); i++) begin
            check_output($sformatf("t5 drain %0d", i), byte_at(popped, base_pop + i), model_q[i]);
        end
        check_output("t5 valid low after drain", valid_o, 0);
        check_output("t5 head holds last", data_o, model_q[model_q.size() - 1]);

        // Reset in the middle of data bit 3 of 0xFF.
        base_rise = rise_cyc.size(); base_ferr = ferr_cyc.size(); base_ovf = ovf_cyc.size();
        drive_line(1'b0, CPB);
        drive_line(1'b1, 3 * CPB + 8);
        check_output("t6 busy before reset", busy_o, 1);
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        check_output("t6 data_o reset", data_o, 0);
        check_output("t6 valid_o reset", valid_o, 0);
        check_output("t6 busy_o reset", busy_o, 0);
        check_output("t6 frame_err_o reset", frame_err_o, 0);
        check_output("t6 overflow_o reset", overflow_o, 0);
        drive_line(1'b1, 8 + 5 * CPB + 20);
        check_output("t6 no byte", rise_cyc.size() - base_rise, 0);
        check_output("t6 no frame_err", ferr_cyc.size() - base_ferr, 0);
        check_output("t6 no overflow", ovf_cyc.size() - base_ovf, 0);
        base_pop = popped.size();
        apply_stimulus(8'h3C, 1'b1);
        drive_line(1'b1, 20);
        check_output("t6 byte after reset", byte_at(popped, base_pop), 8'h3C);

        // Random bytes with random idle gaps, including back-to-back frames.
        model_q.delete();
        base_pop = popped.size(); base_ferr = ferr_cyc.size(); base_ovf = ovf_cyc.size();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            model_q.push_back(b);
            apply_stimulus(b, 1'b1);
            gap = int'($urandom_range(0, 12));
            drive_line(1'b1, gap);
        end
        drive_line(1'b1, 20);
        check_output("rand pop count", popped.size() - base_pop, model_q.size());
        for (int i = 0; i < model_q.size(); i++) begin
            check_output($sformatf("rand byte %0d", i), byte_at(popped, base_pop + i), model_q[i]);
        end
        check_output("rand no frame_err", ferr_cyc.size() - base_ferr, 0);
        check_output("rand no overflow", ovf_cyc.size() - base_ovf, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
